// File: rtl/in_mem_loader.sv
// rtl/in_mem_loader.sv - 16x32 message block loader feeding the SHA-256 control block
// Host fills the buffer over valid/ready; the buffer stays locked until hash_done.
module in_mem_loader #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              cnt,
  input  logic              reset,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] in_mem_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              block_ready,
  output logic              start,
  input  logic              hash_done,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic                start_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic                accept_d;

  assign accept_d = (state_q == S_FILL) && wr_valid;

  always_ff @(posedge cnt or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      word_cnt_q <= '0;
      start_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_FILL: begin
          if (wr_valid) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (wr_ptr_q == LAST_PTR) begin
              wr_ptr_q <= '0;
              state_q  <= S_FULL;
              start_q  <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        S_FULL: begin
          // Release only; the buffer is overwritten word by word by the next block.
          if (hash_done) begin
            state_q    <= S_FILL;
            word_cnt_q <= '0;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  always_ff @(posedge cnt or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept_d) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data     = mem_q[in_mem_addr];
  assign wr_ready    = (state_q == S_FILL);
  assign block_ready = (state_q == S_FULL);
  assign start       = start_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_in_mem_loader.sv
// tb/tb_in_mem_loader.sv - self-checking bench for in_mem_loader
module tb_in_mem_loader;

  logic        cnt;
  logic        reset;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  in_mem_addr;
  logic [31:0] rd_data;
  logic        block_ready;
  logic        start;
  logic        hash_done;
  logic [4:0]  word_cnt;

  in_mem_loader #(.WORD_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .cnt         (cnt),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .in_mem_addr (in_mem_addr),
    .rd_data     (rd_data),
    .block_ready (block_ready),
    .start       (start),
    .hash_done   (hash_done),
    .word_cnt    (word_cnt)
  );

  initial cnt = 1'b0;
  always #20 cnt = ~cnt;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        hd;
    logic        e_ready;
    logic        e_bready;
    logic        e_start;
    logic [4:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[17];
  sb_t  sb_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_full   = 1'b0;
  logic m_start  = 1'b0;
  logic [3:0] m_ptr = '0;
  logic [4:0] m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model of the handshake; expected stored words go to the scoreboard.
  task automatic drive_cycle(input logic v, input logic [31:0] d, input logic hd);
    sb_t e;
    wr_valid  = v;
    wr_data   = d;
    hash_done = hd;
    m_start   = 1'b0;
    if (!m_full) begin
      if (v) begin
        e.addr = m_ptr;
        e.data = d;
        sb_q.push_back(e);
        m_cnt = m_cnt + 1'b1;
        if (m_ptr == 4'd15) begin
          m_full  = 1'b1;
          m_start = 1'b1;
          m_ptr   = '0;
        end else begin
          m_ptr = m_ptr + 1'b1;
        end
      end
    end else if (hd) begin
      m_full = 1'b0;
      m_cnt  = '0;
    end
    @(posedge cnt);
    #1;
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      in_mem_addr = e.addr;
      #1;
      check($sformatf("sb_rd[%0d]", e.addr), rd_data, e.data);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_block_ready"}, {31'd0, block_ready}, {31'd0, m_full});
    check({tag, "_wr_ready"}, {31'd0, wr_ready}, {31'd0, !m_full});
    check({tag, "_start"}, {31'd0, start}, {31'd0, m_start});
    check({tag, "_word_cnt"}, {27'd0, word_cnt}, {27'd0, m_cnt});
  endtask

  initial begin
    reset = 1'b0;
    wr_valid = 1'b1;
    wr_data = 32'hA5A5_A5A5;
    hash_done = 1'b0;
    in_mem_addr = '0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].vld      = (i < 16);
      vecs[i].data     = 32'(i);
      vecs[i].hd       = 1'b0;
      vecs[i].e_ready  = (i < 15);
      vecs[i].e_bready = (i >= 15);
      vecs[i].e_start  = (i == 15);
      vecs[i].e_cnt    = (i < 16) ? 5'(i + 1) : 5'd16;
    end

    // Reset held with wr_valid high
    repeat (2) @(posedge cnt);
    #1;
    check("rst_block_ready", {31'd0, block_ready}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_word_cnt", {27'd0, word_cnt}, 32'd0);
    reset = 1'b1;
    wr_valid = 1'b0;
    #1;
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int a = 0; a < 16; a++) begin
      in_mem_addr = 4'(a);
      #1;
      check($sformatf("rst_rd[%0d]", a), rd_data, 32'd0);
    end

    // Back-to-back full fill from the vector table
    for (int i = 0; i < 17; i++) begin
      drive_cycle(vecs[i].vld, vecs[i].data, vecs[i].hd);
      check($sformatf("fill%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].e_ready});
      check($sformatf("fill%0d_block_ready", i), {31'd0, block_ready}, {31'd0, vecs[i].e_bready});
      check($sformatf("fill%0d_start", i), {31'd0, start}, {31'd0, vecs[i].e_start});
      check($sformatf("fill%0d_word_cnt", i), {27'd0, word_cnt}, {27'd0, vecs[i].e_cnt});
    end
    in_mem_addr = 4'd7;
    #1;
    check("fill_rd7", rd_data, 32'h0000_0007);
    drain();

    // Backpressure in FULL
    in_mem_addr = 4'd0;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
      check($sformatf("bp%0d_wr_ready", k), {31'd0, wr_ready}, 32'd0);
      check($sformatf("bp%0d_rd0", k), rd_data, 32'd0);
    end

    // hash_done together with wr_valid: no write in the release cycle
    drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
    check("rel_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rel_block_ready", {31'd0, block_ready}, 32'd0);
    check("rel_word_cnt", {27'd0, word_cnt}, 32'd0);
    check("rel_rd0", rd_data, 32'd0);
    drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("post_word_cnt", {27'd0, word_cnt}, 32'd1);
    check("post_rd0", rd_data, 32'hDEAD_BEEF);

    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1'b1, 32'h100 + 32'(i), 1'b0);
    end
    check("mid_word_cnt", {27'd0, word_cnt}, 32'd9);
    wr_valid = 1'b0;
    drain();

    // Asynchronous reset between edges
    #5;
    reset = 1'b0;
    #1;
    check("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("arst_block_ready", {31'd0, block_ready}, 32'd0);
    check("arst_start", {31'd0, start}, 32'd0);
    check("arst_word_cnt", {27'd0, word_cnt}, 32'd0);
    in_mem_addr = 4'd3;
    #1;
    check("arst_rd3", rd_data, 32'd0);
    m_full = 1'b0;
    m_ptr  = '0;
    m_cnt  = '0;
    sb_q.delete();
    @(posedge cnt);
    #1;
    reset = 1'b1;

    // Gapped fill with hash_done pulses in FILL
    for (int c = 0; c < 32; c++) begin
      drive_cycle((c % 2) == 0, $urandom, ((c % 4) == 1));
      check_model($sformatf("gap%0d", c));
    end
    check("gap_final_block_ready", {31'd0, block_ready}, 32'd1);
    wr_valid  = 1'b0;
    hash_done = 1'b0;
    drain();

    // Release, then a back-to-back block straight after
    drive_cycle(1'b0, 32'd0, 1'b1);
    check_model("rel2");
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, ~32'(i), 1'b0);
      check_model($sformatf("b2b%0d", i));
    end
    wr_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/in_mem_loader.md
Name: in_mem_loader

Overview:
- Write-side counterpart of the SHA-256 control block's input-memory reads.
- Accepts 16 message words (one 512-bit block) from the host over a valid/ready handshake and stores them in a 16x32 register file.
- Raises block_ready and pulses start once the block is complete.
- Serves words to the control block via its in_mem_addr, and holds the buffer until the control block returns hash_done.

Parameters:
WORD_W, 32, message word width in bits
DEPTH, 16, words per message block
ADDR_W, 4, address width, log2(DEPTH)

Ports:
cnt  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
wr_data  input  WORD_W  host message word
wr_valid  input  1  host word valid
wr_ready  output  1  loader can accept a word
in_mem_addr  input  ADDR_W  read address from control block
rd_data  output  WORD_W  word at in_mem_addr
block_ready  output  1  level: all 16 words loaded, buffer locked
start  output  1  one-cycle pulse on entry to FULL
hash_done  input  1  control block finished with the buffer; releases it
word_cnt  output  ADDR_W+1  words stored in current block, 0..16

Behaviour:
- Reset (reset=0, asynchronous):
  - State = FILL, wr_ptr = 0, word_cnt = 0.
  - All 16 memory words = 0, so rd_data = 0.
  - wr_ready = 1 once reset is released; block_ready = 0, start = 0.
  - Reset asserted mid-fill or in FULL aborts immediately; all partial data is discarded.
- Transfer: a word is accepted on a rising edge where wr_valid=1 and wr_ready=1. wr_valid without wr_ready has no effect; the host must hold the word.
- FSM, two states:
  - FILL:
    - wr_ready = 1.
    - On accept: mem[wr_ptr] <= wr_data, wr_ptr <= wr_ptr+1, word_cnt <= word_cnt+1.
    - On accepting the word at wr_ptr=15: next state FULL, wr_ptr wraps to 0, word_cnt = 16, start = 1 for exactly the next cycle.
    - hash_done in FILL is ignored.
  - FULL:
    - wr_ready = 0, block_ready = 1, memory contents frozen.
    - On hash_done=1: next state FILL, word_cnt <= 0, block_ready <= 0, wr_ready <= 1.
    - No write is accepted in that same cycle, because wr_ready was 0.
    - Memory is not cleared; the next block overwrites it word by word.
- Outputs: block_ready and wr_ready are decoded from state (registered state, no comb path from inputs). start is a registered pulse, high only in the first FULL cycle.
- Read port:
  - rd_data = mem[in_mem_addr], asynchronous/combinational, zero latency, valid in every state.
  - Reading in FILL returns whatever is stored (stale or new); the control block reads only while block_ready=1.
  - A write to the address being read shows on rd_data in the cycle after the edge.
- Back-to-back: wr_valid held high continuously fills 16 words in 16 consecutive cycles. The first word of the next block can be accepted on the first cycle after hash_done returns the FSM to FILL.
- Width rules: wr_ptr is ADDR_W bits and wraps modulo 16. word_cnt is ADDR_W+1 bits and saturates at 16 (it never increments in FULL).

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_valid=1 → wr_ready=1 after release, block_ready=0, start=0, word_cnt=0; in_mem_addr=0..15 all read rd_data=0.
- Full fill: stream words 0x00000000..0x0000000F back-to-back → block_ready=1 and start=1 on the cycle after word 15; start low the following cycle; word_cnt=16; in_mem_addr=7 reads 0x00000007.
- Backpressure: in FULL, drive wr_valid=1 with 0xDEADBEEF for 5 cycles → wr_ready=0, memory unchanged (addr 0 still 0x00000000); then pulse hash_done → next cycle wr_ready=1, word_cnt=0, and 0xDEADBEEF is accepted into addr 0.
- Simultaneous hash_done and wr_valid in FULL → no write that cycle; the write lands in addr 0 one cycle later; word_cnt=1 after it.
- Reset mid-fill: after 9 words (word_cnt=9), assert reset=0 asynchronously between edges → outputs reset immediately; addr 3 reads 0; a fresh 16-word fill then completes normally.
- Gapped writes: toggle wr_valid every other cycle for 16 words → block_ready rises after the 16th accept only (cycle 31); hash_done pulsed during FILL changes nothing.
